// File: rtl/acc_serial_tx_if.sv
// Write-side interface between the processor control unit (master) and the
// serial transmitter (slave).
interface acc_serial_tx_if #(
    parameter int unsigned DATA_WIDTH = 11
);
    logic [DATA_WIDTH-1:0] tx_in;
    logic                  tx_wr;
    logic                  tx_out;
    logic                  tx_busy;
    logic                  tx_done;

    modport master (
        output tx_in,
        output tx_wr,
        input  tx_out,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_in,
        input  tx_wr,
        output tx_out,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/acc_serial_tx.sv
// Serial transmitter for the accumulator word: start bit, DATA_WIDTH data bits
// LSB-first, stop bit, each bit held CLKS_PER_BIT clocks. All outputs registered.
module acc_serial_tx #(
    parameter int unsigned DATA_WIDTH   = 11,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input logic             clock,
    input logic             tx_reset,
    acc_serial_tx_if.slave  tx
);
    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [BitW-1:0]       bit_cnt;
    logic [BaudW-1:0]      baud_cnt;
    logic                  out_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  bit_end;

    assign bit_end    = (baud_cnt == BaudLast);
    assign shift_next = shift_reg >> 1;

    always_ff @(posedge clock or posedge tx_reset) begin
        if (tx_reset) begin
            state     <= StIdle;
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            out_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                StIdle: begin
                    if (tx.tx_wr) begin
                        shift_reg <= tx.tx_in;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        out_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        out_q    <= shift_reg[0];
                        state    <= StData;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_next;
                        if (bit_cnt == BitLast) begin
                            out_q <= 1'b1;
                            state <= StStop;
                        end else begin
                            // Present the next bit on the same edge that shifts it down.
                            bit_cnt <= bit_cnt + 1'b1;
                            out_q   <= shift_next[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= StIdle;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    out_q  <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign tx.tx_out  = out_q;
    assign tx.tx_busy = busy_q;
    assign tx.tx_done = done_q;
endmodule

// File: tb/tb_acc_serial_tx.sv
// Scoreboard bench for acc_serial_tx: a timing-level model queues expected frames,
// a monitor rebuilds frames from the serial line and compares.
module tb_acc_serial_tx;
    localparam int unsigned DW    = 11;
    localparam int unsigned CPB   = 4;
    localparam int          FRAME = (DW + 2) * CPB;

    logic clock    = 1'b0;
    logic tx_reset = 1'b0;

    acc_serial_tx_if #(.DATA_WIDTH(DW)) bus0 ();
    acc_serial_tx_if #(.DATA_WIDTH(DW)) bus1 ();

    acc_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut0 (
        .clock    (clock),
        .tx_reset (tx_reset),
        .tx       (bus0)
    );

    acc_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) dut1 (
        .clock    (clock),
        .tx_reset (tx_reset),
        .tx       (bus1)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line level of cycle i of a frame carrying w, from the frame definition.
    function automatic logic expected_bit(input logic [DW-1:0] w, input int i, input int cpb);
        int b;
        b = i / cpb;
        if (b == 0) return 1'b0;
        else if (b <= DW) return w[b-1];
        else return 1'b1;
    endfunction

    typedef struct {
        logic [DW-1:0] word;
        int            acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc       = 0;
    int   next_free = 0;

    // Reference model: a write is accepted if the line has been free long enough;
    // each frame occupies FRAME cycles plus one done cycle.
    initial forever begin
        @(posedge clock or posedge tx_reset);
        if (tx_reset) begin
            exp_q.delete();
            next_free = 0;
        end else begin
            if (bus0.tx_wr === 1'b1 && cyc >= next_free) begin
                exp_q.push_back('{word: bus0.tx_in, acc: cyc});
                next_free = cyc + FRAME + 1;
            end
            cyc++;
        end
    end

    logic cap[$];
    logic prev_busy = 1'b0;
    int   start_cyc = 0;

    task automatic frame_end();
        exp_t         e;
        logic [63:0]  act_v;
        logic [63:0]  exp_v;
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act_v = '0;
            exp_v = '0;
            for (int i = 0; i < FRAME; i++) begin
                exp_v[i] = expected_bit(e.word, i, CPB);
                act_v[i] = (i < cap.size()) ? cap[i] : 1'bx;
            end
            check("frame_start_latency", start_cyc, e.acc + 1);
            check("frame_busy_len", cap.size(), FRAME);
            check("frame_bits", act_v, exp_v);
        end
        cap.delete();
    endtask

    // Monitor samples at the falling edge, away from the active edge.
    initial forever begin
        @(negedge clock);
        if (tx_reset) begin
            cap.delete();
            prev_busy = 1'b0;
        end else if (bus0.tx_busy === 1'b1) begin
            if (!prev_busy) start_cyc = cyc;
            check("done_while_busy", bus0.tx_done, 0);
            cap.push_back(bus0.tx_out);
            prev_busy = 1'b1;
        end else begin
            if (prev_busy) begin
                check("done_pulse", bus0.tx_done, 1);
                check("line_after_stop", bus0.tx_out, 1);
                frame_end();
            end else begin
                check("idle_line", bus0.tx_out, 1);
                check("idle_done", bus0.tx_done, 0);
            end
            prev_busy = 1'b0;
        end
    end

    task automatic pulse_wr(input logic [DW-1:0] w);
        @(negedge clock);
        bus0.tx_in = w;
        bus0.tx_wr = 1'b1;
        @(negedge clock);
        bus0.tx_wr = 1'b0;
        bus0.tx_in = DW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (bus0.tx_done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("wait_done_in_budget", n < budget, 1);
    endtask

    task automatic run_fast(input logic [DW-1:0] w);
        int          busy_n;
        int          done_at;
        logic [63:0] act_v;
        logic [63:0] exp_v;
        @(negedge clock);
        bus1.tx_in = w;
        bus1.tx_wr = 1'b1;
        @(negedge clock);
        bus1.tx_wr = 1'b0;
        bus1.tx_in = DW'($urandom);
        busy_n  = 0;
        done_at = -1;
        act_v   = '0;
        exp_v   = '0;
        for (int i = 0; i < 16; i++) begin
            if (bus1.tx_busy === 1'b1) begin
                act_v[busy_n] = bus1.tx_out;
                busy_n++;
            end
            if (bus1.tx_done === 1'b1 && done_at < 0) done_at = i;
            @(negedge clock);
        end
        for (int i = 0; i < DW + 2; i++) exp_v[i] = expected_bit(w, i, 1);
        check("fast_busy_len", busy_n, DW + 2);
        check("fast_bits", act_v, exp_v);
        check("fast_done_at", done_at, DW + 2);
    endtask

    initial begin
        int mode;
        int n;
        bus0.tx_in = '0;
        bus0.tx_wr = 1'b0;
        bus1.tx_in = '0;
        bus1.tx_wr = 1'b0;

        // Reset pulse of 2 ns, checked while asserted.
        #1 tx_reset = 1'b1;
        #1;
        check("reset_out", bus0.tx_out, 1);
        check("reset_busy", bus0.tx_busy, 0);
        check("reset_done", bus0.tx_done, 0);
        check("reset_out_fast", bus1.tx_out, 1);
        #1 tx_reset = 1'b0;
        repeat (20) @(negedge clock);

        // Single frame with an ignored write during it.
        pulse_wr(11'b00000110010);
        repeat (8) @(negedge clock);
        pulse_wr(11'b11100000011);
        wait_done(100);

        // Write in the done cycle starts the next frame immediately.
        bus0.tx_in = 11'b10110010010;
        bus0.tx_wr = 1'b1;
        @(negedge clock);
        bus0.tx_wr = 1'b0;
        check("b2b_start_bit", bus0.tx_out, 0);
        check("b2b_busy", bus0.tx_busy, 1);
        wait_done(100);

        // Reset between edges during data bit 5 aborts the frame.
        pulse_wr(DW'($urandom));
        repeat (25) @(negedge clock);
        #2 tx_reset = 1'b1;
        #1;
        check("abort_out", bus0.tx_out, 1);
        check("abort_busy", bus0.tx_busy, 0);
        check("abort_done", bus0.tx_done, 0);
        @(negedge clock);
        @(negedge clock);
        #2 tx_reset = 1'b0;
        repeat (5) @(negedge clock);
        pulse_wr(DW'($urandom));
        wait_done(100);

        // Randomised traffic: pulses with gaps, held strobes, random toggling.
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                pulse_wr(DW'($urandom));
                repeat ($urandom_range(0, 70)) @(negedge clock);
            end else if (mode == 1) begin
                @(negedge clock);
                bus0.tx_wr = 1'b1;
                repeat ($urandom_range(1, 150)) begin
                    bus0.tx_in = DW'($urandom);
                    @(negedge clock);
                end
                bus0.tx_wr = 1'b0;
            end else begin
                repeat (60) begin
                    @(negedge clock);
                    bus0.tx_wr = 1'($urandom_range(0, 1));
                    bus0.tx_in = DW'($urandom);
                end
                @(negedge clock);
                bus0.tx_wr = 1'b0;
            end
        end
        bus0.tx_wr = 1'b0;

        // One clock per bit.
        run_fast(11'b11111111111);
        run_fast(DW'($urandom));
        run_fast(DW'($urandom));

        n = 0;
        while ((exp_q.size() != 0 || bus0.tx_busy === 1'b1) && n < 200) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("drain_in_budget", n < 200, 1);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
